// File: rtl/i2si_deserializer.sv
// rtl/i2si_deserializer.sv - receive-side I2S deserializer presenting stereo pairs over an rts/rtr handshake
//
// Purpose:
//   Samples i2si_sd / i2si_ws on each SCK rising-edge strobe, assembles MSB-first
//   channel words (left-justified, zero-filled when short, truncated when long),
//   pairs a left word with the following right word, and presents the pair to
//   the filter with a ready-to-send / ready-to-receive handshake.
//
// Optional feature:
//   I2SI_OVR_FLAG_EN - adds the sticky overrun output i2si_ovr.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   sck_transition in   one-clk strobe marking the SCK sample point
//   i2si_sd        in   serial data, MSB first
//   i2si_ws        in   word select, 0 = left, 1 = right
//   i2si_filt_lft  out  left sample of the presented pair
//   i2si_filt_rgt  out  right sample of the presented pair
//   i2si_filt_rts  out  presented pair valid
//   i2si_filt_rtr  in   filter ready to receive
//   i2si_ovr       out  sticky overrun flag (I2SI_OVR_FLAG_EN only)

module i2si_deserializer #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_transition,
    input  logic              i2si_sd,
    input  logic              i2si_ws,
    output logic [WORD_W-1:0] i2si_filt_lft,
    output logic [WORD_W-1:0] i2si_filt_rgt,
    output logic              i2si_filt_rts,
    input  logic              i2si_filt_rtr
`ifdef I2SI_OVR_FLAG_EN
    ,
    output logic              i2si_ovr
`endif
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic               ws_q1_q,  ws_q1_d;
    logic               ws_q2_q,  ws_q2_d;
    logic [WORD_W-1:0]  sr_q,     sr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WORD_W-1:0]  hold_q,   hold_d;
    logic [WORD_W-1:0]  lft_q,    lft_d;
    logic [WORD_W-1:0]  rgt_q,    rgt_d;
    logic               rts_q,    rts_d;
`ifdef I2SI_OVR_FLAG_EN
    logic               ovr_q,    ovr_d;
`endif

    // ------------------------------------------------------------------
    // Word assembly (combinational view of this strobe's bit)
    // ------------------------------------------------------------------
    logic               word_start;
    logic               word_end;
    logic [WORD_W-1:0]  sr_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   pad_amt;
    logic [WORD_W-1:0]  word_just;

    always_comb begin
        // The bit sampled now belongs to the channel ws had one strobe ago,
        // so a change between the two previous ws samples marks this bit as
        // an MSB, and a change between now and the previous sample marks it
        // as the last bit of its word.
        word_start = (ws_q1_q != ws_q2_q);
        word_end   = (i2si_ws != ws_q1_q);

        sr_next  = sr_q;
        cnt_next = cnt_q;
        if (word_start) begin
            sr_next  = {{(WORD_W-1){1'b0}}, i2si_sd};
            cnt_next = CNT_W'(1);
        end else if (cnt_q < CNT_W'(WORD_W)) begin
            sr_next  = {sr_q[WORD_W-2:0], i2si_sd};
            cnt_next = cnt_q + CNT_W'(1);
        end

        // cnt_next is always at least 1 here, so the pad is 0..WORD_W-1.
        pad_amt   = CNT_W'(WORD_W) - cnt_next;
        word_just = sr_next << pad_amt;
    end

    // ------------------------------------------------------------------
    // Framing FSM and handshake
    // ------------------------------------------------------------------
    logic pair_done;
    logic xfer;

    always_comb begin
        state_d   = state_q;
        ws_q1_d   = ws_q1_q;
        ws_q2_d   = ws_q2_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        lft_d     = lft_q;
        rgt_d     = rgt_q;
        rts_d     = rts_q;
`ifdef I2SI_OVR_FLAG_EN
        ovr_d     = ovr_q;
`endif
        pair_done = 1'b0;
        xfer      = rts_q && i2si_filt_rtr;

        if (sck_transition) begin
            ws_q1_d = i2si_ws;
            ws_q2_d = ws_q1_q;
            sr_d    = sr_next;
            cnt_d   = cnt_next;

            unique case (state_q)
                ST_SYNC: begin
                    // Only a left-word MSB lets us in; anything earlier
                    // would pair a right word with a missing left word.
                    if (word_start && !ws_q1_q) begin
                        if (word_end) begin
                            hold_d  = word_just;
                            state_d = ST_RIGHT;
                        end else begin
                            state_d = ST_LEFT;
                        end
                    end
                end
                ST_LEFT: begin
                    if (word_end) begin
                        hold_d  = word_just;
                        state_d = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (word_end) begin
                        pair_done = 1'b1;
                        state_d   = ST_LEFT;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end

        // A new pair may load whenever the output slot is empty or is being
        // emptied on this very edge; otherwise it is dropped and the
        // presented pair stays untouched.
        if (pair_done && (!rts_q || i2si_filt_rtr)) begin
            lft_d = hold_q;
            rgt_d = word_just;
            rts_d = 1'b1;
        end else begin
            if (xfer) begin
                rts_d = 1'b0;
            end
`ifdef I2SI_OVR_FLAG_EN
            if (pair_done) begin
                ovr_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SYNC;
            // Both history bits high: a low ws right after reset looks like
            // a left-word start.
            ws_q1_q <= 1'b1;
            ws_q2_q <= 1'b1;
            sr_q    <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            lft_q   <= '0;
            rgt_q   <= '0;
            rts_q   <= 1'b0;
`ifdef I2SI_OVR_FLAG_EN
            ovr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ws_q1_q <= ws_q1_d;
            ws_q2_q <= ws_q2_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            lft_q   <= lft_d;
            rgt_q   <= rgt_d;
            rts_q   <= rts_d;
`ifdef I2SI_OVR_FLAG_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

    assign i2si_filt_lft = lft_q;
    assign i2si_filt_rgt = rgt_q;
    assign i2si_filt_rts = rts_q;
`ifdef I2SI_OVR_FLAG_EN
    assign i2si_ovr      = ovr_q;
`endif

endmodule

// File: tb/tb_i2si_deserializer.sv
// tb/tb_i2si_deserializer.sv - scoreboard bench for i2si_deserializer

module tb_i2si_deserializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck_transition;
    logic        i2si_sd;
    logic        i2si_ws;
    logic [15:0] i2si_filt_lft;
    logic [15:0] i2si_filt_rgt;
    logic        i2si_filt_rts;
    logic        i2si_filt_rtr;
`ifdef I2SI_OVR_FLAG_EN
    logic        i2si_ovr;
`endif

    always #5 clk = ~clk;

    i2si_deserializer #(.WORD_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sck_transition (sck_transition),
        .i2si_sd        (i2si_sd),
        .i2si_ws        (i2si_ws),
        .i2si_filt_lft  (i2si_filt_lft),
        .i2si_filt_rgt  (i2si_filt_rgt),
        .i2si_filt_rts  (i2si_filt_rts),
        .i2si_filt_rtr  (i2si_filt_rtr)
`ifdef I2SI_OVR_FLAG_EN
        ,
        .i2si_ovr       (i2si_ovr)
`endif
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    pair_t exp_q[$];
    pair_t mon_e;
    int    checks = 0;
    int    errors = 0;
    int    gap = 2;
    logic  sd_next = 1'b0;
    int    rts_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the channel word is the first 16 slot bits, MSB first,
    // zero-padded on the right when the slot is shorter.
    function automatic logic [15:0] ref_word(input logic [31:0] v, input int n);
        logic [31:0] t;
        if (n >= 16) t = v >> (n - 16);
        else         t = v << (16 - n);
        return t[15:0];
    endfunction

    function automatic logic [31:0] mask_n(input int n);
        logic [31:0] one;
        one = 32'd1;
        if (n >= 32) return 32'hFFFF_FFFF;
        return (one << n) - 32'd1;
    endfunction

    // Monitor: every transfer pops the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n) begin
            if (i2si_filt_rts) rts_cycles++;
            if (i2si_filt_rts && i2si_filt_rtr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got 0x%0h/0x%0h expected none",
                             i2si_filt_lft, i2si_filt_rgt);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pair_lft", {16'h0, i2si_filt_lft}, {16'h0, mon_e.l});
                    check("pair_rgt", {16'h0, i2si_filt_rgt}, {16'h0, mon_e.r});
                end
            end
        end
    end

    // One SCK: ws is the slot's channel, sd carries the previous slot's bit
    // (WS leads data by one SCK).
    task automatic strobe(input logic ch, input logic b);
        i2si_ws        = ch;
        i2si_sd        = sd_next;
        sd_next        = b;
        sck_transition = 1'b1;
        @(posedge clk); #1;
        if (gap > 1) begin
            sck_transition = 1'b0;
            repeat (gap - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        sck_transition = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic ch, input logic [31:0] v, input int n);
        for (int j = n - 1; j >= 0; j--) strobe(ch, v[j]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        pair_t p;
        p.l = ref_word(l, n);
        p.r = ref_word(r, n);
        exp_q.push_back(p);
        send_word(1'b0, l, n);
        send_word(1'b1, r, n);
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_q.push_back(p);
    endtask

    // Ends the last right word by starting a left slot, then drains.
    task automatic close_frame();
        strobe(1'b0, 1'b0);
        idle(6);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lft"}, {16'h0, i2si_filt_lft}, 32'h0);
        check({tag, "_rgt"}, {16'h0, i2si_filt_rgt}, 32'h0);
        check({tag, "_rts"}, {31'h0, i2si_filt_rts}, 32'h0);
`ifdef I2SI_OVR_FLAG_EN
        check({tag, "_ovr"}, {31'h0, i2si_ovr}, 32'h0);
`endif
    endtask

    task automatic do_reset();
        sck_transition = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        idle(2);
        rst_n = 1'b1;
        rts_cycles = 0;
        idle(1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    logic [31:0] rl, rr;
    int          rn;

    initial begin
        rst_n          = 1'b0;
        sck_transition = 1'b0;
        i2si_sd        = 1'b0;
        i2si_ws        = 1'b1;
        i2si_filt_rtr  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        idle(1);

        // Reset asserted and released in the middle of a right word.
        gap = 2;
        send_word(1'b0, 32'h7777, 16);
        send_word(1'b1, 32'h0088, 8);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midword");
        send_word(1'b1, 32'h0008, 4);
        rst_n = 1'b1;
        send_word(1'b1, 32'h0008, 4);
        send_frame(32'h1111, 32'h2222, 16);
        close_frame();
        check_drained("midword");

        // 16-slot frames, sustained rtr.
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(32'hA5C3, 32'h1234, 16);
        close_frame();
        check("rts_one_cycle_per_pair", rts_cycles, 32'd3);
        check_drained("slot16");

        // 32-slot frames: extra bits ignored.
        do_reset();
        gap = 1;
        send_frame({16'hBEEF, 16'hFFFF}, {16'h0F0F, 16'hFFFF}, 32);
        send_frame({16'hBEEF, 16'hFFFF}, {16'h0F0F, 16'hFFFF}, 32);
        close_frame();
        check_drained("slot32");

        // 12-slot frames: zero-filled LSBs.
        do_reset();
        gap = 3;
        send_frame(32'hABC, 32'h123, 12);
        send_frame(32'hABC, 32'h123, 12);
        close_frame();
        check_drained("slot12");

        // Overrun: rtr low across later pairs.
        do_reset();
        gap = 2;
        i2si_filt_rtr = 1'b0;
        push_pair(16'h0001, 16'h0002);
        send_word(1'b0, 32'h1, 16);
        send_word(1'b1, 32'h2, 16);
        send_word(1'b0, 32'h3, 16);
        send_word(1'b1, 32'h4, 16);
        send_word(1'b0, 32'h5, 16);
        send_word(1'b1, 32'h6, 16);
        send_word(1'b0, 32'h7, 16);
        check("ovr_hold_lft", {16'h0, i2si_filt_lft}, 32'h1);
        check("ovr_hold_rgt", {16'h0, i2si_filt_rgt}, 32'h2);
        check("ovr_hold_rts", {31'h0, i2si_filt_rts}, 32'h1);
`ifdef I2SI_OVR_FLAG_EN
        check("ovr_flag", {31'h0, i2si_ovr}, 32'h1);
`endif
        i2si_filt_rtr = 1'b1;
        idle(1);
        check("ovr_after_xfer_rts", {31'h0, i2si_filt_rts}, 32'h0);
        push_pair(16'h0007, 16'h0008);
        send_word(1'b1, 32'h8, 16);
        close_frame();
`ifdef I2SI_OVR_FLAG_EN
        check("ovr_sticky", {31'h0, i2si_ovr}, 32'h1);
`endif
        check_drained("overrun");

        // rtr asserted on the very strobe that completes the next pair.
        do_reset();
        i2si_filt_rtr = 1'b0;
        push_pair(16'h0A0A, 16'h0B0B);
        push_pair(16'h0C0C, 16'h0D0D);
        send_word(1'b0, 32'h0A0A, 16);
        send_word(1'b1, 32'h0B0B, 16);
        send_word(1'b0, 32'h0C0C, 16);
        send_word(1'b1, 32'h0D0D, 16);
        idle(3);
        i2si_filt_rtr  = 1'b1;
        i2si_ws        = 1'b0;
        i2si_sd        = sd_next;
        sd_next        = 1'b0;
        sck_transition = 1'b1;
        @(posedge clk); #1;
        sck_transition = 1'b0;
        check("simul_rts", {31'h0, i2si_filt_rts}, 32'h1);
        check("simul_lft", {16'h0, i2si_filt_lft}, 32'h0C0C);
        check("simul_rgt", {16'h0, i2si_filt_rgt}, 32'h0D0D);
`ifdef I2SI_OVR_FLAG_EN
        check("simul_ovr", {31'h0, i2si_ovr}, 32'h0);
`endif
        close_frame();
        check_drained("simul");

        // Randomized slot lengths, data and strobe spacing.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int f = 0; f < 8; f++) begin
                gap = $urandom_range(1, 3);
                rn  = $urandom_range(4, 32);
                rl  = $urandom & mask_n(rn);
                rr  = $urandom & mask_n(rn);
                send_frame(rl, rr, rn);
            end
            close_frame();
            check_drained("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2si_deserializer.md
# i2si_deserializer

Receive-side I2S deserializer. It samples the serial data and word-select lines on SCK rising-edge strobes from the clock generator and assembles 16-bit left/right words. Each complete stereo pair is presented to the filter through a ready-to-send / ready-to-receive handshake. It is the input-direction counterpart of `i2so_serializer`: I2S pins in, filter-facing parallel samples out.

## Interface
Parameters:
- `WORD_W`, 16: bits kept per channel word.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sck_transition`  in  1  one-`clk` pulse marking an SCK rising edge, which is the sample point.
- `i2si_sd`  in  1  serial data, MSB first.
- `i2si_ws`  in  1  word select: 0 = left, 1 = right.
- `i2si_filt_lft`  out  16  left sample of the presented pair.
- `i2si_filt_rgt`  out  16  right sample of the presented pair.
- `i2si_filt_rts`  out  1  pair valid (ready to send).
- `i2si_filt_rtr`  in  1  filter ready to receive.
- `i2si_ovr`  out  1  sticky overrun flag; present only with `I2SI_OVR_FLAG_EN`.

## Operation
Sampling:
- All state advances only in cycles where `sck_transition`=1. In other cycles the only logic that acts is the handshake.
- On each strobe, sample `sd` and `ws`. Keep `ws_q1` (ws at the previous strobe) and `ws_q2` (ws at the strobe before that).
- The bit sampled now belongs to channel `ws_q1`. This matches the I2S rule that WS leads the MSB by one SCK.
- Word start: `ws_q1 != ws_q2`. The current bit is that word's MSB, and the bit counter is cleared.
- Word end: the current `ws != ws_q1`. The current bit is the last bit of the word.

Word assembly:
- Shift bits into a 16-bit register, MSB first. The counter saturates at 16, and bits beyond 16 are ignored.
- At word end, if fewer than 16 bits were received, left-justify the word and zero-fill the LSBs.

State machine (reset state SYNC):
- SYNC: discard all bits. Go to LEFT on a strobe with left word start (`ws_q1`=0, `ws_q2`=1); that bit is the left MSB.
- LEFT: collect bits. At word end, latch the left word into a holding register and go to RIGHT.
- RIGHT: collect bits. At word end, the pair is complete; go to LEFT.
- The first right word after reset is therefore never paired with a missing left word.

Handshake:
- A completed pair loads `lft`/`rgt` and sets `rts`.
- A transfer occurs on any `clk` edge with `rts`&&`rtr`.
- After a transfer, `rts` clears unless a new pair loads in the same cycle.
- Pair completes while `rts`=1 and `rtr`=0: overrun. The new pair is dropped and the presented pair is unchanged.
- Pair completes in the same cycle as a transfer: the new pair loads, `rts` stays 1, no overrun.
- `lft`/`rgt` are stable whenever `rts`=1.

Reset (assert at any time, including mid-word):
- `lft`/`rgt` = 0, `rts` = 0, `ovr` = 0.
- State = SYNC. Partial words and the holding register are discarded.
- `ws_q1`/`ws_q2` = 1, so a ws that is low right after reset is treated as a left-word start.

## Timing
- Pair latency: `rts` rises on the `clk` edge that samples the strobe carrying the last right-word bit. Outputs are visible one cycle after that strobe is asserted.
- `rtr` may be asserted before `rts`. A transfer takes one cycle, and sustained `rtr`=1 takes every pair.
- Strobes spaced 1 `clk` apart are supported, so there is no minimum SCK/`clk` ratio beyond 1.
- No combinational path from `rtr` to `rts`.

## Configuration
- `I2SI_OVR_FLAG_EN` defined:
  - port `i2si_ovr` exists.
  - It is set on the cycle after a pair is dropped, and stays set until `rst_n`.
- `I2SI_OVR_FLAG_EN` not defined:
  - no port and no register.
  - Overrun still drops the new pair silently.

## Test plan
- Reset, then drive frames with 16 SCK/channel, left 0xA5C3 and right 0x1234, `rtr`=1 -> one pair with `lft`=0xA5C3, `rgt`=0x1234, `rts` high for exactly 1 cycle per frame.
- 32 SCK/channel slots: left 0xBEEF then 16 bits of 1s, right 0x0F0F then 16 bits of 1s -> `lft`=0xBEEF, `rgt`=0x0F0F.
- 12 SCK/channel: left 0xABC, right 0x123 -> `lft`=0xABC0, `rgt`=0x1230.
- Release reset mid right-word, with the first full pair 0x1111/0x2222 -> the partial right word is never presented; the first `rts` carries 0x1111/0x2222.
- `rtr`=0 across two frames (0x0001/0x0002, then 0x0003/0x0004) -> output holds 0x0001/0x0002 and `i2si_ovr`=1 (macro on). Then `rtr`=1 -> that pair transfers, and the next frame's pair is presented.
- Assert `rtr` on the exact cycle a new pair completes -> old pair transfers, new pair loads, `rts` stays 1, `i2si_ovr` stays 0.
